// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the single-port memory arbiter.
// The starvation guard is built only when MEM_ARB_STARVE_GUARD_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } rd_own_t;

    localparam int MEM_AW_DFLT     = 8;
    localparam int STARVE_MAX_DFLT = 4;
    localparam int STARVE_CNT_W    = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; o_hit flags that the
// limit has been reached so the next contested cycle goes to fetch.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(MAX);

    logic [STARVE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_C)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous SRAM between instruction fetch and data load/store.
// Fetch starvation guard is built only when MEM_ARB_STARVE_GUARD_EN is defined.
//
//   rd_own   | meaning
//   OWN_NONE | no read in flight
//   OWN_I    | fetch read in flight, data returns this cycle
//   OWN_D    | load read in flight, data returns this cycle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MEM_AW     = MEM_AW_DFLT,
    parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    rd_own_t           r_rd_own;
    rd_own_t           w_rd_own_nxt;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_force_i;
    logic              w_i_win;
    logic              w_d_win;
    logic              w_unused_bits;

    assign w_unused_bits = ^{i_addr[31:MEM_AW+2], i_addr[1:0],
                             d_addr[31:MEM_AW+2], d_addr[1:0]};

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic w_starve_hit;

    arb_starve_ctr #(
        .MAX   (STARVE_MAX)
    ) u_starve_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (i_req & ~w_i_win),
        .i_clr (w_i_win | ~i_req),
        .o_hit (w_starve_hit)
    );

    assign w_force_i = w_starve_hit;
`else
    assign w_force_i = 1'b0;
`endif

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        w_i_win      = 1'b0;
        w_d_win      = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_rd_own_nxt = OWN_NONE;
        if (rst_n) begin
            w_i_win = i_req & (~d_req | w_force_i);
            w_d_win = d_req & ~w_i_win;
        end
        if (w_i_win) begin
            mem_en       = 1'b1;
            mem_addr     = i_addr[MEM_AW+1:2];
            w_rd_own_nxt = OWN_I;
        end else if (w_d_win) begin
            mem_en       = 1'b1;
            mem_we       = d_we;
            mem_addr     = d_addr[MEM_AW+1:2];
            mem_wdata    = d_wdata;
            w_rd_own_nxt = d_we ? OWN_NONE : OWN_D;
        end
    end

    assign i_gnt = w_i_win;
    assign d_gnt = w_d_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_own <= OWN_NONE;
        end else begin
            r_rd_own <= w_rd_own_nxt;
        end
    end

    // The SRAM presents read data in the cycle after the grant; steer it
    // straight through to the owner and keep a copy so the port holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (r_rd_own == OWN_I) r_i_rdata <= mem_rdata;
            if (r_rd_own == OWN_D) r_d_rdata <= mem_rdata;
        end
    end

    assign i_rvalid = (r_rd_own == OWN_I);
    assign d_rvalid = (r_rd_own == OWN_D);
    assign i_rdata  = (r_rd_own == OWN_I) ? mem_rdata : r_i_rdata;
    assign d_rdata  = (r_rd_own == OWN_D) ? mem_rdata : r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous SRAM.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

    localparam int DATA_W = 32;
    localparam int MEM_AW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0;
    logic [31:0]       i_addr = '0;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [31:0]       d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    int n_checks = 0;
    int n_errors = 0;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    mem_arbiter #(
        .DATA_W     (DATA_W),
        .MEM_AW     (MEM_AW),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit exp_ig, exp_irv, exp_drv;

        for (int a = 0; a < (1<<MEM_AW); a++) mem[a] = 32'h1000_0000 + a;
        mem[0] = 32'hA5A5_0000;
        mem[3] = 32'h0303_0303;
        mem[4] = 32'h2402_0005;
        mem[5] = 32'h5555_AAAA;
        mem[8] = 32'h8888_1234;
        mem[9] = 32'h9999_0009;

        // reset, with a fetch request held to prove grants are blocked
        i_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_i_gnt",    32'(i_gnt), 32'd0);
        chk("rst_mem_en",   32'(mem_en), 32'd0);
        chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        i_req = 1'b0;
        rst_n = 1'b1;

        // fetch only, granted in the first cycle after release
        i_req = 1'b1; i_addr = 32'h10;
        #1;
        chk("f_i_gnt",    32'(i_gnt), 32'd1);
        chk("f_d_gnt",    32'(d_gnt), 32'd0);
        chk("f_mem_en",   32'(mem_en), 32'd1);
        chk("f_mem_we",   32'(mem_we), 32'd0);
        chk("f_mem_addr", 32'(mem_addr), 32'd4);
        tick();
        i_req = 1'b0;
        #1;
        chk("f_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("f_i_rdata",  i_rdata, 32'h2402_0005);
        chk("f_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("f_idle_en",  32'(mem_en), 32'd0);
        chk("f_idle_adr", 32'(mem_addr), 32'd0);

        // contested read: data first, fetch next cycle
        tick();
        i_req = 1'b1; i_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        #1;
        chk("c_d_gnt",    32'(d_gnt), 32'd1);
        chk("c_i_gnt",    32'(i_gnt), 32'd0);
        chk("c_mem_addr", 32'(mem_addr), 32'd8);
        tick();
        d_req = 1'b0;
        #1;
        chk("c_d_rvalid",  32'(d_rvalid), 32'd1);
        chk("c_d_rdata",   d_rdata, 32'h8888_1234);
        chk("c_i_rvalid0", 32'(i_rvalid), 32'd0);
        chk("c_i_hold",    i_rdata, 32'h2402_0005);
        chk("c_i_gnt1",    32'(i_gnt), 32'd1);
        chk("c_mem_addr1", 32'(mem_addr), 32'd5);
        tick();
        i_req = 1'b0;
        #1;
        chk("c_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("c_i_rdata",  i_rdata, 32'h5555_AAAA);
        chk("c_d_rv_off", 32'(d_rvalid), 32'd0);
        chk("c_d_hold",   d_rdata, 32'h8888_1234);

        // store then load at the same address
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("s_d_gnt",     32'(d_gnt), 32'd1);
        chk("s_mem_we",    32'(mem_we), 32'd1);
        chk("s_mem_addr",  32'(mem_addr), 32'd16);
        chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        d_we = 1'b0;
        #1;
        chk("s_no_rvalid", 32'(d_rvalid), 32'd0);
        chk("l_d_gnt",     32'(d_gnt), 32'd1);
        chk("l_mem_we",    32'(mem_we), 32'd0);
        tick();
        d_req = 1'b0;
        #1;
        chk("l_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("l_d_rdata",  d_rdata, 32'hDEAD_BEEF);

        // sustained data traffic against a waiting fetch
        tick();
        i_req = 1'b1; i_addr = 32'h0C;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        for (int k = 1; k <= 10; k++) begin
            #1;
            exp_ig  = GUARD && (k == 5);
            exp_irv = GUARD && (k == 6);
            exp_drv = (k >= 2) && !exp_irv;
            chk($sformatf("st%0d_i_gnt", k),    32'(i_gnt), 32'(exp_ig));
            chk($sformatf("st%0d_d_gnt", k),    32'(d_gnt), 32'(!exp_ig));
            chk($sformatf("st%0d_i_rvalid", k), 32'(i_rvalid), 32'(exp_irv));
            chk($sformatf("st%0d_d_rvalid", k), 32'(d_rvalid), 32'(exp_drv));
            if (exp_irv) chk("st_i_rdata", i_rdata, 32'h0303_0303);
            tick();
            if (exp_ig) i_req = 1'b0;
        end
        d_req = 1'b0;
        #1;
        chk("st_after_i_gnt", 32'(i_gnt), 32'(!GUARD));
        tick();
        i_req = 1'b0;

        // address wrap above the memory size
        tick();
        i_req = 1'b1; i_addr = 32'h400;
        #1;
        chk("w_i_gnt",    32'(i_gnt), 32'd1);
        chk("w_mem_addr", 32'(mem_addr), 32'd0);
        tick();
        i_req = 1'b0;
        #1;
        chk("w_i_rdata", i_rdata, 32'hA5A5_0000);

        // reset in the cycle after a read grant drops the response
        tick();
        i_req = 1'b1; i_addr = 32'h10;
        #1;
        chk("r_i_gnt", 32'(i_gnt), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("r_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("r_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("r_mem_en",   32'(mem_en), 32'd0);
        i_req = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("r_rel_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("r_rel_mem_en",   32'(mem_en), 32'd0);
        chk("r_rel_i_rdata",  i_rdata, 32'd0);
        tick();
        chk("r_rel2_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("r_rel2_d_rvalid", 32'(d_rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one synchronous word-addressed SRAM between the CPU instruction-fetch port and the data load/store port. Sits between the `cpu` core and a unified memory macro, replacing separate instruction/data arrays. Grants at most one access per cycle, returns read data with fixed one-cycle latency, and prevents fetch starvation under sustained data traffic.

## Interface
Parameters:
- `DATA_W`, 32, data word width.
- `MEM_AW`, 8, memory word-index width (256 words).
- `STARVE_MAX`, 4, consecutive denied fetch cycles before fetch is forced to win; range 1..15.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_req`  in  1  fetch request; held until granted.
- `i_addr`  in  32  fetch byte address.
- `i_gnt`  out  1  fetch accepted this cycle.
- `i_rvalid`  out  1  fetch data valid.
- `i_rdata`  out  DATA_W  fetch data.
- `d_req`  in  1  data request; held until granted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data access accepted this cycle.
- `d_rvalid`  out  1  load data valid (never asserted for stores).
- `d_rdata`  out  DATA_W  load data.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  MEM_AW  word index = granted `addr[MEM_AW+1:2]`.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after `mem_en` with `mem_we`=0.

## Operation
- Requesters hold `req` and address/data stable until `gnt`; `req` must not depend combinationally on `gnt`.
- Arbitration per cycle: only one requesting → it wins. Both requesting → data wins, unless starvation guard forces fetch.
- Winner: `gnt` high, `mem_en`=1, `mem_we`=`d_we` (0 for fetch), `mem_addr`/`mem_wdata` from winner. No request → `mem_en`=0, `mem_addr`/`mem_wdata` hold 0.
- `addr[1:0]` ignored; `addr[31:MEM_AW+2]` ignored (wraps into memory).
- Read-owner register `rd_own` ∈ {NONE, I, D} records each granted read; next cycle routes `mem_rdata` to owner's `rdata` with `rvalid` for one cycle. Non-owner `rdata` holds previous value.
- Stores: `d_gnt` only; no `d_rvalid`; `rd_own` = NONE.
- Starvation counter `starve_cnt` (4 bits): increments when `i_req` high and `i_gnt` low; clears on `i_gnt` or `i_req` low; saturates at `STARVE_MAX`. At `STARVE_MAX`, fetch wins next contested cycle.
- Back-to-back grants every cycle allowed; a read response and a new grant coexist in the same cycle.

## Timing
- Reset (async assert, sync deassert in pipeline sense): all outputs 0, `rd_own`=NONE, `starve_cnt`=0. In-flight read at reset is dropped: no `rvalid` after release.
- `gnt`, `mem_*`: combinational from `req` and registered state, same cycle T.
- `rvalid`/`rdata`: registered, cycle T+1 for read granted in T. Latency fixed at 1.
- First grant possible in first cycle after `rst_n` rises.
- Both `rvalid`s are never high in the same cycle.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: starvation counter and forced fetch win as above.
- Undefined: strict data priority; counter not synthesized; fetch stalls for as long as `d_req` is held high.

## Structure
- Package `mem_arb_pkg`: `rd_own_t` enum (`OWN_NONE`, `OWN_I`, `OWN_D`), default `MEM_AW`, `STARVE_MAX` constants.
- Sub-module `arb_starve_ctr`: saturating counter with `inc`, `clr`, `hit` output; instantiated only under `MEM_ARB_STARVE_GUARD_EN`.

## Test plan
- Fetch only: `i_req`, `i_addr`=0x10, mem[4]=0x2402_0005 → `i_gnt` T, `mem_addr`=4, `i_rvalid`=1, `i_rdata`=0x2402_0005 at T+1.
- Contested read: `i_req`=`d_req`=1, `d_addr`=0x20 → `d_gnt` T, `d_rdata`=mem[8] at T+1; `i_gnt` at T+1, `i_rvalid` at T+2.
- Store then load same address: store 0xDEAD_BEEF to 0x40, then load 0x40 → no `d_rvalid` for store; load returns 0xDEAD_BEEF one cycle after its grant.
- Starvation (macro on, `STARVE_MAX`=4): `d_req` held 10 cycles with `i_req` → `i_gnt` on 5th contested cycle, then data resumes; macro off → no `i_gnt` until `d_req` drops.
- Reset mid-read: assert `rst_n`=0 cycle after read grant → `i_rvalid`, `d_rvalid`, `mem_en` 0 immediately and stay 0 after release until new request.
- Address wrap: `i_addr`=0x400 → `mem_addr`=0, data = mem[0].
